// File: rtl/serv_mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp with a programmable tick prescaler and a
// Wishbone-style register port. Drives the machine timer interrupt pending level.
module serv_mtimer #(
  parameter int PRESCALE_W     = 8,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_mtip
);

  localparam logic [2:0] ADR_MTIME_LO    = 3'd0;
  localparam logic [2:0] ADR_MTIME_HI    = 3'd1;
  localparam logic [2:0] ADR_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] ADR_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] ADR_CTRL        = 3'd4;

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic [PRESCALE_W-1:0] div;
  logic [PRESCALE_W-1:0] div_wr;
  logic [PRESCALE_W-1:0] pcnt;
  logic                  irq_en;
  logic                  run;
  logic [31:0]           mtime_hi_shadow;
  logic [31:0]           ctrl_word;
  logic [31:0]           rdata;
  logic                  access;
  logic                  wr;
  logic                  rd;
  logic                  tick;

  // An access is only taken while no ack is outstanding, which forces an idle cycle between acks.
  assign access = i_wb_cyc & ~o_wb_ack;
  assign wr     = access & i_wb_we;
  assign rd     = access & ~i_wb_we;
  assign tick   = run & (pcnt == div);

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = sel[i] ? wdat[8*i +: 8] : old_val[8*i +: 8];
    return res;
  endfunction

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    ctrl_word                  = '0;
    ctrl_word[8 +: PRESCALE_W] = div;
    ctrl_word[1]               = irq_en;
    ctrl_word[0]               = run;
  end

  always_comb begin
    div_wr = div;
    for (int j = 0; j < PRESCALE_W; j++)
      if (i_wb_sel[(8 + j) / 8]) div_wr[j] = i_wb_dat[8 + j];
  end

  always_comb begin
    rdata = '0;
    case (i_wb_adr)
      ADR_MTIME_LO:    rdata = mtime[31:0];
      ADR_MTIME_HI:    rdata = mtime_hi_shadow;
      ADR_MTIMECMP_LO: rdata = mtimecmp[31:0];
      ADR_MTIMECMP_HI: rdata = mtimecmp[63:32];
      ADR_CTRL:        rdata = ctrl_word;
      default:         rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime    <= '0;
      mtimecmp <= '1;
      div      <= '0;
      irq_en   <= 1'b0;
      run      <= 1'b0;
      pcnt     <= '0;
      o_wb_ack <= 1'b0;
      o_wb_dat <= '0;
      o_mtip   <= 1'b0;
    end else begin
      o_wb_ack <= access;
      if (rd) o_wb_dat <= rdata;

      if (wr && i_wb_adr == ADR_CTRL) begin
        div    <= div_wr;
        irq_en <= i_wb_sel[0] ? i_wb_dat[1] : irq_en;
        run    <= i_wb_sel[0] ? i_wb_dat[0] : run;
      end

      if (wr && i_wb_adr == ADR_CTRL) pcnt <= '0;
      else if (tick)                  pcnt <= '0;
      else if (run)                   pcnt <= pcnt + PRESCALE_W'(1);

      // A software write to either mtime half wins over the tick for that cycle.
      if (wr && i_wb_adr == ADR_MTIME_LO)
        mtime[31:0] <= byte_merge(mtime[31:0], i_wb_dat, i_wb_sel);
      else if (wr && i_wb_adr == ADR_MTIME_HI)
        mtime[63:32] <= byte_merge(mtime[63:32], i_wb_dat, i_wb_sel);
      else if (tick)
        mtime <= mtime + 64'd1;

      if (wr && i_wb_adr == ADR_MTIMECMP_LO)
        mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], i_wb_dat, i_wb_sel);
      if (wr && i_wb_adr == ADR_MTIMECMP_HI)
        mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], i_wb_dat, i_wb_sel);

      o_mtip <= irq_en & (mtime >= mtimecmp);
    end
  end

  // The shadow latches the upper half on a low-half read so a 32-bit master sees a coherent 64-bit value.
  if (RESET_STRATEGY == "NONE") begin : gen_shadow_noreset
    // NOTE: this holding register is left unreset on purpose; software always reads MTIME_LO first.
    always_ff @(posedge i_clk)
      if (rd && i_wb_adr == ADR_MTIME_LO) mtime_hi_shadow <= mtime[63:32];
  end else begin : gen_shadow_reset
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)                            mtime_hi_shadow <= '0;
      else if (rd && i_wb_adr == ADR_MTIME_LO) mtime_hi_shadow <= mtime[63:32];
  end

endmodule

// File: tb/tb_serv_mtimer.sv
// Self-checking bench for serv_mtimer: register table vectors plus timed sequences for ticks,
// wrap, shadow coherence, tick/write collision, ack cadence and asynchronous reset.
module tb_serv_mtimer;

  logic        clk;
  logic        rst_n;
  logic        cyc;
  logic        we;
  logic [2:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic [31:0] o_dat;
  logic        ack;
  logic        mtip;

  serv_mtimer dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wb_cyc (cyc),
    .i_wb_we  (we),
    .i_wb_adr (adr),
    .i_wb_dat (dat),
    .i_wb_sel (sel),
    .o_wb_dat (o_dat),
    .o_wb_ack (ack),
    .o_mtip   (mtip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[18];
  logic [31:0] sb[$];
  logic [31:0] exp_dat;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One bus transfer; the expected read data (or unchanged data for writes) is queued at issue
  // and compared when the ack arrives.
  task automatic bus(input string name, input logic w, input logic [2:0] a,
                     input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp);
    logic        got;
    logic [31:0] e;
    sb.push_back(w ? exp_dat : exp);
    if (!w) exp_dat = exp;
    cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(posedge clk); #1;
      got = ack;
    end
    cyc = 1'b0; we = 1'b0;
    e = sb.pop_front();
    check({name, " ack"}, 64'(got), 64'd1);
    if (got) check({name, " data"}, 64'(o_dat), 64'(e));
  endtask

  task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus(name, 1'b0, a, 32'h0, 4'h0, exp);
  endtask

  task automatic wr(input string name, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    bus(name, 1'b1, a, d, s, 32'h0);
  endtask

  task automatic do_reset();
    cyc = 1'b0; we = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_dat = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 3'd5, 32'h0,         4'h0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 3'd0, 32'h0,         4'h0, 32'h0000_0000};
    vecs[2]  = '{1'b0, 3'd1, 32'h0,         4'h0, 32'h0000_0000};
    vecs[3]  = '{1'b0, 3'd4, 32'h0,         4'h0, 32'h0000_0000};
    vecs[4]  = '{1'b0, 3'd3, 32'h0,         4'h0, 32'hFFFF_FFFF};
    vecs[5]  = '{1'b0, 3'd2, 32'h0,         4'h0, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b1, 3'd2, 32'h1234_5678, 4'h5, 32'h0};
    vecs[7]  = '{1'b0, 3'd2, 32'h0,         4'h0, 32'hFF34_FF78};
    vecs[8]  = '{1'b1, 3'd4, 32'hFFFF_FFFC, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, 3'd4, 32'h0,         4'h0, 32'h0000_FF00};
    vecs[10] = '{1'b1, 3'd6, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[11] = '{1'b0, 3'd6, 32'h0,         4'h0, 32'h0000_0000};
    vecs[12] = '{1'b1, 3'd1, 32'hCAFE_F00D, 4'hC, 32'h0};
    vecs[13] = '{1'b0, 3'd1, 32'h0,         4'h0, 32'h0000_0000};
    vecs[14] = '{1'b0, 3'd0, 32'h0,         4'h0, 32'h0000_0000};
    vecs[15] = '{1'b0, 3'd1, 32'h0,         4'h0, 32'hCAFE_0000};
    vecs[16] = '{1'b1, 3'd3, 32'h0000_0000, 4'hF, 32'h0};
    vecs[17] = '{1'b0, 3'd3, 32'h0,         4'h0, 32'h0000_0000};

    rst_n = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0; exp_dat = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ack", 64'(ack), 64'd0);
    check("reset dat", 64'(o_dat), 64'd0);
    check("reset mtip", 64'(mtip), 64'd0);
    rst_n = 1'b1;

    // Register map, byte enables, CTRL masking, reserved addresses, shadow behaviour.
    for (int i = 0; i < 18; i++)
      if (vecs[i].we) wr($sformatf("vec%0d", i), vecs[i].adr, vecs[i].dat, vecs[i].sel);
      else            rd($sformatf("vec%0d", i), vecs[i].adr, vecs[i].exp);

    // mtime = CAFE0000_00000000 >= mtimecmp: enabling irq raises mtip one cycle later and it holds.
    wr("ctrl irq", 3'd4, 32'h0000_0002, 4'h1);
    check("mtip latency", 64'(mtip), 64'd0);
    @(posedge clk); #1;
    check("mtip set", 64'(mtip), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("mtip held", 64'(mtip), 64'd1);
    wr("cmp raise", 3'd3, 32'hFFFF_FFFF, 4'hF);
    check("mtip pre-clear", 64'(mtip), 64'd1);
    @(posedge clk); #1;
    check("mtip cleared", 64'(mtip), 64'd0);

    // div=0 compare at 10: mtime equals the edge count since the CTRL write.
    do_reset();
    wr("c27 ctrl", 3'd4, 32'h0000_0003, 4'hF);
    wr("c27 cmphi", 3'd3, 32'h0000_0000, 4'hF);
    wr("c27 cmplo", 3'd2, 32'h0000_000A, 4'hF);
    repeat (6) @(posedge clk);
    #1;
    check("c27 mtip at mtime=10", 64'(mtip), 64'd0);
    @(posedge clk); #1;
    check("c27 mtip one later", 64'(mtip), 64'd1);
    rd("c27 lo a", 3'd0, 32'd11);
    rd("c27 lo b", 3'd0, 32'd13);

    // div=3: one tick every four cycles, then frozen with run=0.
    do_reset();
    wr("c28 ctrl", 3'd4, 32'h0000_0301, 4'h3);
    for (int i = 0; i < 5; i++) rd($sformatf("c28 lo%0d", i), 3'd0, 32'(i / 2));
    wr("c28 stop", 3'd4, 32'h0000_0300, 4'h3);
    rd("c28 frozen a", 3'd0, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    rd("c28 frozen b", 3'd0, 32'd3);

    // 64-bit wrap from FFFF_FFFF_FFFF_FFFE after two ticks.
    do_reset();
    wr("c29 hi", 3'd1, 32'hFFFF_FFFF, 4'hF);
    wr("c29 lo", 3'd0, 32'hFFFF_FFFE, 4'hF);
    rd("c29 rd lo", 3'd0, 32'hFFFF_FFFE);
    rd("c29 rd hi", 3'd1, 32'hFFFF_FFFF);
    wr("c29 run", 3'd4, 32'h0000_0001, 4'hF);
    wr("c29 stop", 3'd4, 32'h0000_0000, 4'hF);
    rd("c29 wrap lo", 3'd0, 32'h0000_0000);
    rd("c29 wrap hi", 3'd1, 32'h0000_0000);

    // Shadow keeps the upper half seen at the low read while mtime carries into it.
    do_reset();
    wr("c30 lo", 3'd0, 32'hFFFF_FFFF, 4'hF);
    rd("c30 rd lo", 3'd0, 32'hFFFF_FFFF);
    wr("c30 run", 3'd4, 32'h0000_0001, 4'hF);
    repeat (5) @(posedge clk);
    #1;
    rd("c30 shadow hi", 3'd1, 32'h0000_0000);
    rd("c30 rd lo2", 3'd0, 32'h0000_0006);
    rd("c30 new hi", 3'd1, 32'h0000_0001);

    // Byte write to MTIME_LO on a tick cycle replaces the increment.
    do_reset();
    wr("c31 lo", 3'd0, 32'h0000_00FF, 4'hF);
    wr("c31 run", 3'd4, 32'h0000_0001, 4'hF);
    wr("c31 byte", 3'd0, 32'h0000_00AB, 4'h1);
    wr("c31 stop", 3'd4, 32'h0000_0000, 4'hF);
    rd("c31 rd lo", 3'd0, 32'h0000_01AD);

    // Held cyc gives alternating acks; async reset during an ack clears ack and mtip at once.
    do_reset();
    wr("c32 cmphi", 3'd3, 32'h0, 4'hF);
    wr("c32 cmplo", 3'd2, 32'h0, 4'hF);
    wr("c32 irq", 3'd4, 32'h0000_0002, 4'hF);
    @(posedge clk); #1;
    check("c32 mtip", 64'(mtip), 64'd1);
    cyc = 1'b1; we = 1'b0; adr = 3'd5;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("c32 ack%0d", i), 64'(ack), 64'(i % 2));
      if (i < 5) begin
        @(posedge clk); #1;
      end
    end
    rst_n = 1'b0;
    #1;
    check("c32 rst ack", 64'(ack), 64'd0);
    check("c32 rst mtip", 64'(mtip), 64'd0);
    cyc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("c32 post ack", 64'(ack), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
